// File: rtl/pulse_frame_ctrl.sv
// rtl/pulse_frame_ctrl.sv - pulse-map frame sequencer and BRAM write-port arbiter
//
// Each accepted start clears every BRAM word, then runs a generation window
// of `len` cycles. During that window the pulse and pin writers share port A
// under round-robin arbitration. The frame ends with a one-cycle frame_done.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, abort               frame request (IDLE only), return to IDLE
//   gen_cycles                 generation window length, latched on start
//   pulse_req/addr/data, gnt   pulse writer request and combinational grant
//   pin_req/addr/data, gnt     pin writer request and combinational grant
//   bram_addr/data_in/we/en    registered BRAM port A (byte address)
//   gen_en, busy, frame_done   status decoded from the state register

module pulse_frame_ctrl #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       gen_cycles,
    input  logic              pulse_req,
    input  logic [AW-1:0]     pulse_addr,
    input  logic [DATA_W-1:0] pulse_data,
    output logic              pulse_gnt,
    input  logic              pin_req,
    input  logic [AW-1:0]     pin_addr,
    input  logic [DATA_W-1:0] pin_data,
    output logic              pin_gnt,
    output logic [31:0]       bram_addr,
    output logic [DATA_W-1:0] bram_data_in,
    output logic              bram_we,
    output logic              bram_en,
    output logic              gen_en,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_GEN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [31:0]       len;
    logic [31:0]       gen_cnt;
    logic [AW-1:0]     clr_idx;
    logic              last_pin;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, grants and the write decided this cycle
    always_comb begin
        state_next = state;
        pulse_gnt  = 1'b0;
        pin_gnt    = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_idx;
                if (clr_idx == CLR_LAST) begin
                    state_next = (len != 32'd0) ? S_GEN : S_DONE;
                end
            end
            S_GEN: begin
                // On a tie, last_pin=1 means pin went last, so pulse wins.
                if (pulse_req && (!pin_req || last_pin)) begin
                    pulse_gnt = 1'b1;
                    wr_en     = 1'b1;
                    wr_addr   = pulse_addr;
                    wr_data   = pulse_data;
                end else if (pin_req) begin
                    pin_gnt = 1'b1;
                    wr_en   = 1'b1;
                    wr_addr = pin_addr;
                    wr_data = pin_data;
                end
                if (gen_cnt == len - 32'd1) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Abort overrides everything: no grant, no new write, back to IDLE.
        if (abort) begin
            state_next = S_IDLE;
            pulse_gnt  = 1'b0;
            pin_gnt    = 1'b0;
            wr_en      = 1'b0;
        end
    end

    // Frame counters and arbitration history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len      <= 32'd0;
            gen_cnt  <= 32'd0;
            clr_idx  <= '0;
            last_pin <= 1'b1;
        end else begin
            if (state == S_IDLE && start && !abort) begin
                len     <= gen_cycles;
                gen_cnt <= 32'd0;
                clr_idx <= '0;
            end
            if (state == S_CLEAR) begin
                clr_idx <= clr_idx + AW'(1);
            end
            if (state == S_GEN) begin
                gen_cnt <= gen_cnt + 32'd1;
            end
            if (pulse_gnt) begin
                last_pin <= 1'b0;
            end else if (pin_gnt) begin
                last_pin <= 1'b1;
            end
        end
    end

    // Registered BRAM port: address and data hold when no write is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_we      <= 1'b0;
            bram_addr    <= 32'd0;
            bram_data_in <= '0;
        end else begin
            bram_we <= wr_en;
            if (wr_en) begin
                bram_addr    <= {{(30 - AW){1'b0}}, wr_addr, 2'b00};
                bram_data_in <= wr_data;
            end
        end
    end

    assign bram_en    = bram_we;
    assign gen_en     = (state == S_GEN);
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE);

endmodule
